// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte-stream
// requesters using round-robin arbitration with bounded bursts. It honours the
// host flow control (rts_i) and runs the tx core's start/busy handshake,
// launching one byte per start pulse.
//
// Optional feature macro: UART_TX_ARB_ID_PREFIX_EN. When it is defined, each
// grant first sends a header byte {4'hA, g[3:0]}. That header gives no ready
// pulse and does not count toward the burst limit.
//
// Ports:
//   clk_i        master clock
//   rst_i        synchronous reset, active-high
//   req_valid_i  per-requester byte valid            [NUM_REQ]
//   req_data_i   per-requester byte, req i at [8i+:8] [8*NUM_REQ]
//   req_ready_o  one-cycle accept pulse per byte      [NUM_REQ]
//   rts_i        host flow control, 1 = may transmit
//   tx_busy_i    tx core busy (start .. end of stop bit)
//   tx_start_o   one-cycle start pulse to the tx core
//   tx_data_o    byte to the tx core, held until the next load
//   grant_o      one-hot current owner, zero when idle [NUM_REQ]
//   active_o     1 while any grant is held
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic                   rts_i,
  input  logic                   tx_busy_i,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   active_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [CNT_W-1:0]   burst_q;
`ifdef UART_TX_ARB_ID_PREFIX_EN
  logic               hdr_pend_q;
`endif

  logic [NUM_REQ-1:0] rot_c;
  logic [IDX_W-1:0]   off_c;
  logic [SUM_W-1:0]   sum_c;
  logic               pick_vld_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               cur_vld_c;
  logic [7:0]         cur_data_c;
  logic [IDX_W-1:0]   nxt_ptr_c;

  // Round-robin pick: rotate valids so ptr_q sits at bit 0, take the lowest
  // set bit, then map the offset back to an absolute index.
  always_comb begin
    rot_c      = NUM_REQ'({req_valid_i, req_valid_i} >> ptr_q);
    pick_vld_c = |rot_c;
    off_c      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_c[i]) off_c = IDX_W'(i);
    end
    sum_c = SUM_W'(ptr_q) + SUM_W'(off_c);
    if (sum_c >= SUM_W'(NUM_REQ)) sum_c = sum_c - SUM_W'(NUM_REQ);
    pick_idx_c = IDX_W'(sum_c);
  end

  // Current owner's valid/data, and the pointer it leaves behind on release.
  always_comb begin
    cur_vld_c  = 1'b0;
    cur_data_c = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        cur_vld_c  = req_valid_i[i];
        cur_data_c = req_data_i[8*i +: 8];
      end
    end
    nxt_ptr_c = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  end

  // Arbitration FSM. All outputs are registered, and the pulses clear by default.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      burst_q     <= '0;
`ifdef UART_TX_ARB_ID_PREFIX_EN
      hdr_pend_q  <= 1'b0;
`endif
      tx_start_o  <= 1'b0;
      tx_data_o   <= 8'h00;
      req_ready_o <= '0;
      grant_o     <= '0;
      active_o    <= 1'b0;
    end else begin
      tx_start_o  <= 1'b0;
      req_ready_o <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld_c) begin
            gidx_q   <= pick_idx_c;
            grant_o  <= NUM_REQ'(1) << pick_idx_c;
            active_o <= 1'b1;
            burst_q  <= '0;
`ifdef UART_TX_ARB_ID_PREFIX_EN
            hdr_pend_q <= 1'b1;
`endif
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (rts_i && !tx_busy_i) begin
            if (cur_vld_c) begin
              tx_start_o <= 1'b1;
              state_q    <= ST_WAIT_HI;
`ifdef UART_TX_ARB_ID_PREFIX_EN
              if (hdr_pend_q) begin
                // Header byte: no accept pulse, no burst credit used.
                tx_data_o  <= {4'hA, 4'(gidx_q)};
                hdr_pend_q <= 1'b0;
              end else begin
                tx_data_o   <= cur_data_c;
                req_ready_o <= grant_o;
                burst_q     <= burst_q + 1'b1;
              end
`else
              tx_data_o   <= cur_data_c;
              req_ready_o <= grant_o;
              burst_q     <= burst_q + 1'b1;
`endif
            end else begin
              // Requester withdrew: release without sending.
              grant_o  <= '0;
              active_o <= 1'b0;
              ptr_q    <= nxt_ptr_c;
              state_q  <= ST_IDLE;
            end
          end
        end
        ST_WAIT_HI: begin
          if (tx_busy_i) state_q <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!tx_busy_i) begin
            if ((burst_q == CNT_W'(MAX_BURST)) || !cur_vld_c) begin
              grant_o  <= '0;
              active_o <= 1'b0;
              ptr_q    <= nxt_ptr_c;
              state_q  <= ST_IDLE;
            end else begin
              state_q  <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rts;
  logic            tx_busy;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [NR-1:0]   grant;
  logic            active;

  int n_cmp = 0;
  int n_err = 0;
  int stray = 0;
  int frame_len = 12;
  int busy_cnt = 0;

  logic [7:0]  rq [NR][$];
  logic [15:0] log_q[$];
  logic [15:0] exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .rts_i(rts), .tx_busy_i(tx_busy),
    .tx_start_o(tx_start), .tx_data_o(tx_data),
    .grant_o(grant), .active_o(active)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // tx core: busy from the cycle after start for frame_len cycles
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= frame_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // requesters pop on ready; monitor logs every start as {ready, grant, data}
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      req_valid[i] = (rq[i].size() > 0);
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
    if (tx_start) log_q.push_back({req_ready, grant, tx_data});
    else if (req_ready != '0) stray++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_data(input int g, input logic [7:0] d);
    exp_q.push_back({4'(1 << g), 4'(1 << g), d});
  endtask

  task automatic exp_hdr(input int g);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    exp_q.push_back({4'h0, 4'(1 << g), 4'hA, 4'(g)});
`else
    if (g < 0) exp_q.push_back(16'h0);
`endif
  endtask

  function automatic logic [7:0] first_byte(input int g, input logic [7:0] d);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    return {4'hA, 4'(g)} | (d & 8'h00);
`else
    return d | 8'(g & 0);
`endif
  endfunction

  function automatic logic [3:0] first_ready(input int g);
`ifdef UART_TX_ARB_ID_PREFIX_EN
    return 4'(g & 0);
`else
    return 4'(1 << g);
`endif
  endfunction

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(queues_empty() && grant == '0 && !tx_busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_entry%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(tx_start), 32'd0);
    check({tag, "_data"},  32'(tx_data),  32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_grant"}, 32'(grant),    32'd0);
    check({tag, "_active"}, 32'(active),  32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    rts = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single byte with a full-length frame
    frame_len = 5208;
    rq[0].push_back(8'h81);
    exp_hdr(0); exp_data(0, 8'h81);
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_active", 32'(active), 32'd1);
    check("t1_nostart", 32'(tx_start), 32'd0);
    tick();
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data", 32'(tx_data), 32'(first_byte(0, 8'h81)));
    check("t1_ready", 32'(req_ready), 32'(first_ready(0)));
    wait_done("t1", 12000);
    check("t1_rel_grant", 32'(grant), 32'd0);
    check("t1_rel_active", 32'(active), 32'd0);
    check("t1_data_held", 32'(tx_data), 32'h81);
    compare_log("t1");
    frame_len = 12;

    // Round robin from ptr 0, then again from ptr 3
    pulse_reset();
    rq[1].push_back(8'h11); rq[2].push_back(8'h22);
    exp_hdr(1); exp_data(1, 8'h11); exp_hdr(2); exp_data(2, 8'h22);
    wait_done("t2a", 500);
    compare_log("t2a");
    rq[1].push_back(8'h13); rq[2].push_back(8'h24);
    exp_hdr(1); exp_data(1, 8'h13); exp_hdr(2); exp_data(2, 8'h24);
    wait_done("t2b", 500);
    compare_log("t2b");

    // Burst limit: req 0 wants 6 bytes, req 3 gets a turn after 4
    pulse_reset();
    for (int b = 0; b < 6; b++) rq[0].push_back(8'hAA + 8'(b));
    rq[3].push_back(8'h33);
    exp_hdr(0);
    for (int b = 0; b < 4; b++) exp_data(0, 8'hAA + 8'(b));
    exp_hdr(3); exp_data(3, 8'h33);
    exp_hdr(0); exp_data(0, 8'hAE); exp_data(0, 8'hAF);
    wait_done("t3", 2000);
    compare_log("t3");

    // Flow control: hold off, release, then drop rts mid-byte
    rts = 1'b0;
    rq[0].push_back(8'h55); rq[0].push_back(8'h56);
    exp_hdr(0); exp_data(0, 8'h55); exp_data(0, 8'h56);
    repeat (1000) tick();
    check("t4_held_nostart", 32'(log_q.size()), 32'd0);
    check("t4_held_grant", 32'(grant), 32'h1);
    rts = 1'b1;
    tick();
    check("t4_start", 32'(tx_start), 32'd1);
    check("t4_data", 32'(tx_data), 32'(first_byte(0, 8'h55)));
    repeat (3) tick();
    rts = 1'b0;
    repeat (frame_len + 20) tick();
    check("t4_stall_count", 32'(log_q.size()), 32'd1);
    check("t4_stall_grant", 32'(grant), 32'h1);
    rts = 1'b1;
    wait_done("t4", 500);
    compare_log("t4");

    // Reset while waiting for the tx core to finish
    rq[0].push_back(8'h50); rq[0].push_back(8'h51);
    n = 0;
    while (!tx_start && n < 100) begin tick(); n++; end
    check("t5_start_seen", 32'(n < 100), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("t5_reset");
    rst = 1'b0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    log_q.delete();
    exp_q.delete();
    rq[0].push_back(8'h60); rq[1].push_back(8'h61);
    exp_hdr(0); exp_data(0, 8'h60); exp_hdr(1); exp_data(1, 8'h61);
    tick();
    check("t5_ptr0_grant", 32'(grant), 32'h1);
    wait_done("t5", 500);
    compare_log("t5");

`ifdef UART_TX_ARB_ID_PREFIX_EN
    // Header then data, one ready pulse only
    rq[2].push_back(8'h01);
    exp_q.push_back(16'h04A2);
    exp_q.push_back(16'h4401);
    wait_done("t6", 500);
    compare_log("t6");
`endif

    check("stray_ready", 32'(stray), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
